ternary_spi_shifter: RTL and testbench

//   Word-level serializer/deserializer for the ternary SPI link. Accepts an
//   N-trit word through a valid/ready handshake and shifts it out MSB-trit

---
 rtl/ternary_spi_shifter.sv | 205 ++++++++++++++++++++
 tb/tb_ternary_spi_shifter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ternary_spi_shifter.sv
// Ternary SPI word shifter: sends an N-trit word MSB-trit first on O_mosi with a ternary SCK and captures I_miso.
// Optional check trit enabled by defining TERNARY_SPI_PARITY_EN.
module ternary_spi_shifter #(
  parameter int TRITS   = 6,
  parameter int CLK_DIV = 2
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic [2*TRITS-1:0] I_tx_data,
  input  logic               I_tx_valid,
  output logic               O_tx_ready,
  output logic [2*TRITS-1:0] O_rx_data,
  output logic               O_rx_valid,
  output logic               O_err,
  output logic               O_busy,
  output logic [1:0]         O_mosi,
  output logic [1:0]         O_sck,
  input  logic [1:0]         I_miso,
  output logic [1:0]         O_dbg_state
);

  // Handshake: a word transfers on the rising edge where I_tx_valid && O_tx_ready;
  // the sender holds I_tx_data stable until then, and O_tx_ready is high only in IDLE.

  localparam logic [1:0] T_ZERO  = 2'b00;
  localparam logic [1:0] T_PLUS  = 2'b01;
  localparam logic [1:0] T_MINUS = 2'b10;

`ifdef TERNARY_SPI_PARITY_EN
  localparam int NT = TRITS + 1;
`else
  localparam int NT = TRITS;
`endif
  localparam int CW = (NT > 1) ? $clog2(NT) : 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] TR_LAST = CW'(NT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [PW-1:0]      phase_cnt;
  logic [CW-1:0]      trit_cnt;
  logic [2*TRITS-1:0] tx_shift;
  logic [2*TRITS-1:0] rx_shift;
  logic [2*TRITS-1:0] rx_next;
  logic [2*TRITS-1:0] rx_data;
  logic               rx_valid;
  logic               err_acc;
  logic               err_out;
  logic               accept;
  logic               phase_last;
  logic               trit_last;
  logic [1:0]         miso_clean;
  logic [1:0]         cur_trit;

`ifdef TERNARY_SPI_PARITY_EN
  localparam logic [CW-1:0] TR_CHECK = CW'(TRITS);
  logic [1:0] tx_chk;
  logic [1:0] rx_sum;
  logic       is_check;

  // Trit codes ZERO/PLUS/MINUS coincide with residues 0/1/2, so a residue is its own check trit.
  function automatic logic [1:0] mod3_add(input logic [1:0] acc, input logic [1:0] t);
    logic [2:0] s;
    s = {1'b0, acc} + {1'b0, (t == 2'b11) ? T_ZERO : t};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] word_sum(input logic [2*TRITS-1:0] w);
    logic [1:0] s;
    s = T_ZERO;
    for (int k = 0; k < TRITS; k++) s = mod3_add(s, w[2*k +: 2]);
    return s;
  endfunction

  assign is_check = (trit_cnt == TR_CHECK);
  assign cur_trit = is_check ? tx_chk : tx_shift[2*TRITS-1 -: 2];
`else
  assign cur_trit = tx_shift[2*TRITS-1 -: 2];
`endif

  assign accept     = (state == S_IDLE) && I_tx_valid;
  assign phase_last = (phase_cnt == PH_LAST);
  assign trit_last  = (trit_cnt == TR_LAST);
  assign miso_clean = (I_miso == 2'b11) ? T_ZERO : I_miso;

  always_comb begin
    rx_next      = rx_shift << 2;
    rx_next[1:0] = miso_clean;
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    O_tx_ready = 1'b0;
    O_busy     = 1'b1;
    O_sck      = T_ZERO;
    O_mosi     = T_ZERO;
    case (state)
      S_IDLE: begin
        O_tx_ready = 1'b1;
        O_busy     = 1'b0;
        if (accept) state_nxt = S_HI;
      end
      S_HI: begin
        O_sck  = T_PLUS;
        O_mosi = (cur_trit == 2'b11) ? T_ZERO : cur_trit;
        if (phase_last) state_nxt = S_LO;
      end
      S_LO: begin
        O_sck  = T_MINUS;
        O_mosi = (cur_trit == 2'b11) ? T_ZERO : cur_trit;
        if (phase_last) state_nxt = trit_last ? S_IDLE : S_HI;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      phase_cnt <= '0;
      trit_cnt  <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      err_acc   <= 1'b0;
      err_out   <= 1'b0;
`ifdef TERNARY_SPI_PARITY_EN
      tx_chk    <= T_ZERO;
      rx_sum    <= T_ZERO;
`endif
    end else begin
      rx_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            tx_shift  <= I_tx_data;
            rx_shift  <= '0;
            err_acc   <= 1'b0;
            err_out   <= 1'b0;
            phase_cnt <= '0;
            trit_cnt  <= '0;
`ifdef TERNARY_SPI_PARITY_EN
            tx_chk    <= word_sum(I_tx_data);
            rx_sum    <= T_ZERO;
`endif
          end
        end
        S_HI: begin
          if (phase_last) begin
            phase_cnt <= '0;
`ifdef TERNARY_SPI_PARITY_EN
            if (is_check) begin
              err_acc <= err_acc | (I_miso != rx_sum);
            end else begin
              rx_shift <= rx_next;
              rx_sum   <= mod3_add(rx_sum, I_miso);
              err_acc  <= err_acc | (I_miso == 2'b11);
            end
`else
            rx_shift <= rx_next;
            err_acc  <= err_acc | (I_miso == 2'b11);
`endif
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        S_LO: begin
          if (phase_last) begin
            phase_cnt <= '0;
            if (trit_last) begin
              trit_cnt <= '0;
              rx_data  <= rx_shift;
              err_out  <= err_acc;
              rx_valid <= 1'b1;
            end else begin
              trit_cnt <= trit_cnt + CW'(1);
              tx_shift <= tx_shift << 2;
            end
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign O_rx_data   = rx_data;
  assign O_rx_valid  = rx_valid;
  assign O_err       = err_out;
  assign O_dbg_state = state;

endmodule

// File: tb/tb_ternary_spi_shifter.sv
// Bench for ternary_spi_shifter with TRITS=3, CLK_DIV=1; define TERNARY_SPI_PARITY_EN to exercise the check trit.
module tb_ternary_spi_shifter;

  localparam int TRITS   = 3;
  localparam int CLK_DIV = 1;
`ifdef TERNARY_SPI_PARITY_EN
  localparam int NT     = TRITS + 1;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int NT     = TRITS;
  localparam bit PAR_EN = 1'b0;
`endif

  logic       I_clk = 1'b0;
  logic       I_rst_n;
  logic [5:0] I_tx_data;
  logic       I_tx_valid;
  logic       O_tx_ready;
  logic [5:0] O_rx_data;
  logic       O_rx_valid;
  logic       O_err;
  logic       O_busy;
  logic [1:0] O_mosi;
  logic [1:0] O_sck;
  logic [1:0] I_miso;
  logic [1:0] O_dbg_state;

  ternary_spi_shifter #(.TRITS(TRITS), .CLK_DIV(CLK_DIV)) dut (
    .I_clk(I_clk), .I_rst_n(I_rst_n),
    .I_tx_data(I_tx_data), .I_tx_valid(I_tx_valid), .O_tx_ready(O_tx_ready),
    .O_rx_data(O_rx_data), .O_rx_valid(O_rx_valid), .O_err(O_err), .O_busy(O_busy),
    .O_mosi(O_mosi), .O_sck(O_sck), .I_miso(I_miso), .O_dbg_state(O_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 I_clk = ~I_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  // mode 0: loopback, 1: I_miso held at miso_c, 2: loopback except the last trit of the transfer forced to miso_c
  typedef struct {
    logic [5:0] tx;
    logic [1:0] mode;
    logic [1:0] miso_c;
    logic [5:0] exp_mosi;
    logic [1:0] exp_chk;
    logic [5:0] exp_rx_np;
    logic       exp_err_np;
    logic [5:0] exp_rx_p;
    logic       exp_err_p;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  // Entered at the negedge of the first HI cycle; leaves at the negedge of the last LO cycle.
  task automatic shift_cycles(input logic [1:0] mode, input logic [1:0] mc,
                              input logic [5:0] exp_data, input logic [1:0] exp_chk,
                              input string tag);
    logic [31:0] act_mosi, exp_mosi_seq, act_sck, exp_sck_seq;
    logic [1:0]  t_exp;
    int          bad_ctl;
    int          t;
    act_mosi = '0; exp_mosi_seq = '0; act_sck = '0; exp_sck_seq = '0; bad_ctl = 0;
    for (int c = 0; c < 2*NT; c++) begin
      if (c > 0) @(negedge I_clk);
      t = c / 2;
      t_exp = (t < TRITS) ? exp_data[2*(TRITS-1-t) +: 2] : exp_chk;
      act_mosi     = {act_mosi[29:0], O_mosi};
      exp_mosi_seq = {exp_mosi_seq[29:0], t_exp};
      act_sck      = {act_sck[29:0], O_sck};
      exp_sck_seq  = {exp_sck_seq[29:0], (c % 2 == 0) ? 2'b01 : 2'b10};
      if (O_busy !== 1'b1 || O_tx_ready !== 1'b0 || O_rx_valid !== 1'b0) bad_ctl++;
      if (mode == 2'd1 || (mode == 2'd2 && t == NT-1)) I_miso = mc;
      else I_miso = O_mosi;
    end
    check({tag, " mosi_seq"}, act_mosi, exp_mosi_seq);
    check({tag, " sck_seq"}, act_sck, exp_sck_seq);
    check({tag, " xfer_ctl_bad_cycles"}, 32'(bad_ctl), 32'd0);
  endtask

  task automatic check_done(input logic exp_err, input string tag);
    logic [5:0] exp_rx;
    @(negedge I_clk);
    check({tag, " rx_valid"}, 32'(O_rx_valid), 32'd1);
    check({tag, " tx_ready_at_rx_valid"}, 32'(O_tx_ready), 32'd1);
    if (exp_q.size() == 0) begin
      check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      exp_rx = exp_q.pop_front();
      check({tag, " rx_data"}, 32'(O_rx_data), 32'(exp_rx));
    end
    check({tag, " err"}, 32'(O_err), 32'(exp_err));
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge I_clk);
    I_tx_data = v.tx; I_tx_valid = 1'b1; I_miso = 2'b00;
    @(negedge I_clk);
    I_tx_valid = 1'b0;
    exp_q.push_back(PAR_EN ? v.exp_rx_p : v.exp_rx_np);
    shift_cycles(v.mode, v.miso_c, v.exp_mosi, v.exp_chk, tag);
    check_done(PAR_EN ? v.exp_err_p : v.exp_err_np, tag);
    @(negedge I_clk);
    check({tag, " rx_valid_one_cycle"}, 32'(O_rx_valid), 32'd0);
    check({tag, " rx_data_held"}, 32'(O_rx_data), 32'(PAR_EN ? v.exp_rx_p : v.exp_rx_np));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " sck"}, 32'(O_sck), 32'd0);
    check({tag, " mosi"}, 32'(O_mosi), 32'd0);
    check({tag, " rx_data"}, 32'(O_rx_data), 32'd0);
    check({tag, " rx_valid"}, 32'(O_rx_valid), 32'd0);
    check({tag, " err"}, 32'(O_err), 32'd0);
    check({tag, " busy"}, 32'(O_busy), 32'd0);
    check({tag, " tx_ready"}, 32'(O_tx_ready), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int seen_valid;
    //             tx        mode  mc     mosi      chk    rx_np     e_np  rx_p      e_p
    vecs[0] = '{6'b01_10_00, 2'd0, 2'b00, 6'b01_10_00, 2'b00, 6'b01_10_00, 1'b0, 6'b01_10_00, 1'b0};
    vecs[1] = '{6'b11_01_01, 2'd0, 2'b00, 6'b00_01_01, 2'b10, 6'b00_01_01, 1'b0, 6'b00_01_01, 1'b0};
    vecs[2] = '{6'b10_10_10, 2'd1, 2'b11, 6'b10_10_10, 2'b00, 6'b00_00_00, 1'b1, 6'b00_00_00, 1'b1};
    vecs[3] = '{6'b00_01_10, 2'd1, 2'b01, 6'b00_01_10, 2'b00, 6'b01_01_01, 1'b0, 6'b01_01_01, 1'b1};
    vecs[4] = '{6'b01_11_10, 2'd0, 2'b00, 6'b01_00_10, 2'b00, 6'b01_00_10, 1'b0, 6'b01_00_10, 1'b0};
    vecs[5] = '{6'b01_01_00, 2'd0, 2'b00, 6'b01_01_00, 2'b10, 6'b01_01_00, 1'b0, 6'b01_01_00, 1'b0};
    vecs[6] = '{6'b01_01_00, 2'd2, 2'b01, 6'b01_01_00, 2'b10, 6'b01_01_01, 1'b0, 6'b01_01_00, 1'b1};
    vecs[7] = '{6'b01_01_00, 2'd2, 2'b11, 6'b01_01_00, 2'b10, 6'b01_01_00, 1'b1, 6'b01_01_00, 1'b1};

    I_rst_n = 1'b0; I_tx_data = '0; I_tx_valid = 1'b0; I_miso = 2'b00;
    repeat (2) @(negedge I_clk);
    check_reset_outputs("reset");
    I_rst_n = 1'b1;
    @(negedge I_clk);
    check_reset_outputs("idle_after_reset");

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Back-to-back: valid held high; data changed while busy must not affect the running word.
    @(negedge I_clk);
    I_tx_data = 6'b10_00_01; I_tx_valid = 1'b1; I_miso = 2'b00;
    @(negedge I_clk);
    I_tx_data = 6'b00_10_01;
    exp_q.push_back(6'b10_00_01);
    shift_cycles(2'd0, 2'b00, 6'b10_00_01, 2'b00, "b2b_first");
    check_done(1'b0, "b2b_first");
    @(negedge I_clk);
    I_tx_valid = 1'b0;
    check("b2b second_start_busy", 32'(O_busy), 32'd1);
    check("b2b second_start_sck", 32'(O_sck), 32'd1);
    exp_q.push_back(6'b00_10_01);
    shift_cycles(2'd0, 2'b00, 6'b00_10_01, 2'b00, "b2b_second");
    check_done(1'b0, "b2b_second");

    // Reset mid-transfer: outputs return to reset values at once, no rx_valid afterwards.
    @(negedge I_clk);
    I_tx_data = 6'b01_10_01; I_tx_valid = 1'b1;
    @(negedge I_clk);
    I_tx_valid = 1'b0;
    @(negedge I_clk);
    @(negedge I_clk);
    check("midreset busy_before", 32'(O_busy), 32'd1);
    #1 I_rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    @(negedge I_clk);
    I_rst_n = 1'b1;
    seen_valid = 0;
    for (int c = 0; c < 4*NT; c++) begin
      @(negedge I_clk);
      if (O_rx_valid === 1'b1) seen_valid++;
    end
    check("midreset no_rx_valid", 32'(seen_valid), 32'd0);
    check("midreset idle_ready", 32'(O_tx_ready), 32'd1);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
